// File: rtl/ocext_index_tracker_pkg.sv
// Shared types and helpers for the index tracker: command opcodes and width derivation.
package ocext_index_tracker_pkg;

    typedef enum logic [1:0] {
        OpNone,
        OpSet,
        OpClr,
        OpSetClr
    } op_e;

    // Bits needed to hold a population count in 0..w inclusive.
    function automatic int unsigned count_width(input int unsigned w);
        return $clog2(w + 1);
    endfunction

endpackage

// File: rtl/ocext_binary_decoder.sv
// Combinational binary-to-one-hot decoder with an in-range flag for non-power-of-two widths.
module ocext_binary_decoder #(
    parameter int unsigned WIDTH = 4,
    parameter int unsigned IW    = $clog2(WIDTH)
) (
    input  logic [IW-1:0]    index_i,
    output logic [WIDTH-1:0] onehot_o,
    output logic             in_range_o
);

    always_comb begin
        onehot_o   = '0;
        in_range_o = 1'b0;
        for (int i = 0; i < int'(WIDTH); i++) begin
            if (index_i == IW'(i)) begin
                onehot_o[i] = 1'b1;
                in_range_o  = 1'b1;
            end
        end
    end

endmodule

// File: rtl/ocext_index_tracker.sv
// Occupancy bitmap driven by binary set/clear commands, with registered count and full/empty.
module ocext_index_tracker
    import ocext_index_tracker_pkg::*;
#(
    parameter int unsigned WIDTH = 4,
    parameter int unsigned IW    = $clog2(WIDTH),
    parameter int unsigned CW    = count_width(WIDTH)
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             set_valid,
    output logic             set_ready,
    input  logic [IW-1:0]    set_index,
    input  logic             clr_valid,
    input  logic [IW-1:0]    clr_index,
    output logic [WIDTH-1:0] output_unencoded,
    output logic [CW-1:0]    output_count,
    output logic             output_full,
    output logic             output_empty,
    output logic [WIDTH-1:0] set_onehot,
    output logic             error
);

    logic [WIDTH-1:0] bitmap_q, bitmap_d;
    logic [CW-1:0]    count_q, count_d;
    logic             full_q, full_d;
    logic             empty_q, empty_d;
    logic [WIDTH-1:0] onehot_q, onehot_d;
    logic             error_q, error_d;

    logic [WIDTH-1:0] set_oh, clr_oh;
    logic             set_in_range, clr_in_range;
    logic             set_acc, set_hit, clr_hit, same_idx;
    logic             set_eff, clr_eff, set_err, clr_err;

    ocext_binary_decoder #(
        .WIDTH (WIDTH),
        .IW    (IW)
    ) u_set_dec (
        .index_i    (set_index),
        .onehot_o   (set_oh),
        .in_range_o (set_in_range)
    );

    ocext_binary_decoder #(
        .WIDTH (WIDTH),
        .IW    (IW)
    ) u_clr_dec (
        .index_i    (clr_index),
        .onehot_o   (clr_oh),
        .in_range_o (clr_in_range)
    );

    always_comb begin
        set_acc  = set_valid && !full_q;
        set_hit  = |(bitmap_q & set_oh);
        clr_hit  = |(bitmap_q & clr_oh);
        // Same-slot set+clear behaves as clear-then-set and is never an error.
        same_idx = set_acc && clr_valid && set_in_range && clr_in_range &&
                   (set_index == clr_index);
        set_eff  = set_acc && set_in_range && !set_hit;
        clr_eff  = clr_valid && clr_in_range && clr_hit && !same_idx;
        set_err  = set_acc && !same_idx && (!set_in_range || set_hit);
        clr_err  = clr_valid && !same_idx && (!clr_in_range || !clr_hit);

        bitmap_d = (bitmap_q & ~({WIDTH{clr_valid}} & clr_oh)) | ({WIDTH{set_acc}} & set_oh);
        count_d  = count_q + CW'(set_eff) - CW'(clr_eff);
        full_d   = (count_d == CW'(WIDTH));
        empty_d  = (count_d == '0);
        onehot_d = {WIDTH{set_acc}} & set_oh;
        error_d  = set_err || clr_err;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            bitmap_q <= '0;
            count_q  <= '0;
            full_q   <= 1'b0;
            empty_q  <= 1'b1;
            onehot_q <= '0;
            error_q  <= 1'b0;
        end else begin
            bitmap_q <= bitmap_d;
            count_q  <= count_d;
            full_q   <= full_d;
            empty_q  <= empty_d;
            onehot_q <= onehot_d;
            error_q  <= error_d;
        end
    end

    assign set_ready        = !full_q;
    assign output_unencoded = bitmap_q;
    assign output_count     = count_q;
    assign output_full      = full_q;
    assign output_empty     = empty_q;
    assign set_onehot       = onehot_q;
    assign error            = error_q;

    count_matches_bitmap: assert property (@(posedge clock) disable iff (reset)
        count_q == CW'($countones(bitmap_q)));

endmodule

// File: tb/tb_ocext_index_tracker.sv
// Directed bench for the index tracker: a WIDTH=4 instance and a WIDTH=5 instance.
module tb_ocext_index_tracker;
    import ocext_index_tracker_pkg::*;

    logic clock = 1'b0;
    logic reset;

    logic       a_set_valid, a_set_ready, a_clr_valid;
    logic [1:0] a_set_index, a_clr_index;
    logic [3:0] a_bitmap, a_onehot;
    logic [2:0] a_count;
    logic       a_full, a_empty, a_error;

    logic       b_set_valid, b_set_ready, b_clr_valid;
    logic [2:0] b_set_index, b_clr_index;
    logic [4:0] b_bitmap, b_onehot;
    logic [2:0] b_count;
    logic       b_full, b_empty, b_error;

    int checks = 0;
    int errors = 0;

    always #5 clock = ~clock;

    ocext_index_tracker #(.WIDTH(4)) u_dut_a (
        .clock            (clock),
        .reset            (reset),
        .set_valid        (a_set_valid),
        .set_ready        (a_set_ready),
        .set_index        (a_set_index),
        .clr_valid        (a_clr_valid),
        .clr_index        (a_clr_index),
        .output_unencoded (a_bitmap),
        .output_count     (a_count),
        .output_full      (a_full),
        .output_empty     (a_empty),
        .set_onehot       (a_onehot),
        .error            (a_error)
    );

    ocext_index_tracker #(.WIDTH(5)) u_dut_b (
        .clock            (clock),
        .reset            (reset),
        .set_valid        (b_set_valid),
        .set_ready        (b_set_ready),
        .set_index        (b_set_index),
        .clr_valid        (b_clr_valid),
        .clr_index        (b_clr_index),
        .output_unencoded (b_bitmap),
        .output_count     (b_count),
        .output_full      (b_full),
        .output_empty     (b_empty),
        .set_onehot       (b_onehot),
        .error            (b_error)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic drive_a(input op_e op, input int unsigned si, input int unsigned ci);
        a_set_valid = (op == OpSet) || (op == OpSetClr);
        a_clr_valid = (op == OpClr) || (op == OpSetClr);
        a_set_index = 2'(si);
        a_clr_index = 2'(ci);
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic chk_a(input string tag, input logic [3:0] bm, input logic [2:0] cnt,
                         input logic full, input logic empty, input logic [3:0] oh,
                         input logic err, input logic rdy);
        chk({tag, ".bitmap"}, 32'(a_bitmap), 32'(bm));
        chk({tag, ".count"},  32'(a_count),  32'(cnt));
        chk({tag, ".full"},   32'(a_full),   32'(full));
        chk({tag, ".empty"},  32'(a_empty),  32'(empty));
        chk({tag, ".onehot"}, 32'(a_onehot), 32'(oh));
        chk({tag, ".error"},  32'(a_error),  32'(err));
        chk({tag, ".ready"},  32'(a_set_ready), 32'(rdy));
    endtask

    initial begin
        reset = 1'b1;
        drive_a(OpNone, 0, 0);
        b_set_valid = 1'b0;
        b_clr_valid = 1'b0;
        b_set_index = '0;
        b_clr_index = '0;
        #3;
        chk_a("reset", 4'b0000, 3'd0, 1'b0, 1'b1, 4'b0000, 1'b0, 1'b1);
        chk("reset.b_empty", 32'(b_empty), 32'd1);
        step();
        step();
        reset = 1'b0;

        // Fill all four slots.
        drive_a(OpSet, 0, 0); step();
        chk_a("set0", 4'b0001, 3'd1, 1'b0, 1'b0, 4'b0001, 1'b0, 1'b1);
        drive_a(OpSet, 1, 0); step();
        chk_a("set1", 4'b0011, 3'd2, 1'b0, 1'b0, 4'b0010, 1'b0, 1'b1);
        drive_a(OpSet, 2, 0); step();
        chk_a("set2", 4'b0111, 3'd3, 1'b0, 1'b0, 4'b0100, 1'b0, 1'b1);
        drive_a(OpSet, 3, 0); step();
        chk_a("set3", 4'b1111, 3'd4, 1'b1, 1'b0, 4'b1000, 1'b0, 1'b0);

        // Full: set 2 blocked while clear 1 lands; then the held set is a duplicate.
        drive_a(OpSetClr, 2, 1); step();
        chk_a("fullclr", 4'b1101, 3'd3, 1'b0, 1'b0, 4'b0000, 1'b0, 1'b1);
        drive_a(OpSet, 2, 0); step();
        chk_a("dupset", 4'b1101, 3'd3, 1'b0, 1'b0, 4'b0100, 1'b1, 1'b1);
        drive_a(OpNone, 0, 0); step();
        chk_a("idle1", 4'b1101, 3'd3, 1'b0, 1'b0, 4'b0000, 1'b0, 1'b1);

        // Down to 0100.
        drive_a(OpClr, 0, 0); step();
        drive_a(OpClr, 0, 3); step();
        chk_a("clr03", 4'b0100, 3'd1, 1'b0, 1'b0, 4'b0000, 1'b0, 1'b1);

        drive_a(OpSetClr, 2, 2); step();
        chk_a("same2", 4'b0100, 3'd1, 1'b0, 1'b0, 4'b0100, 1'b0, 1'b1);
        drive_a(OpSetClr, 0, 2); step();
        chk_a("s0c2", 4'b0001, 3'd1, 1'b0, 1'b0, 4'b0001, 1'b0, 1'b1);
        drive_a(OpClr, 0, 2); step();
        chk_a("clrzero", 4'b0001, 3'd1, 1'b0, 1'b0, 4'b0000, 1'b1, 1'b1);

        // Build 0110, then assert reset between edges.
        drive_a(OpSetClr, 1, 0); step();
        drive_a(OpSet, 2, 0); step();
        chk_a("b0110", 4'b0110, 3'd2, 1'b0, 1'b0, 4'b0100, 1'b0, 1'b1);
        drive_a(OpNone, 0, 0);
        #2 reset = 1'b1;
        #1;
        chk_a("midrst", 4'b0000, 3'd0, 1'b0, 1'b1, 4'b0000, 1'b0, 1'b1);
        #2 reset = 1'b0;
        drive_a(OpSet, 3, 0); step();
        chk_a("postrst", 4'b1000, 3'd1, 1'b0, 1'b0, 4'b1000, 1'b0, 1'b1);
        drive_a(OpNone, 0, 0);

        // WIDTH=5: out-of-range commands.
        chk("w5.ready", 32'(b_set_ready), 32'd1);
        b_set_valid = 1'b1; b_set_index = 3'd6; step();
        chk("w5.oor.error",  32'(b_error),  32'd1);
        chk("w5.oor.bitmap", 32'(b_bitmap), 32'd0);
        chk("w5.oor.onehot", 32'(b_onehot), 32'd0);
        chk("w5.oor.count",  32'(b_count),  32'd0);
        chk("w5.oor.empty",  32'(b_empty),  32'd1);
        b_set_index = 3'd4; step();
        chk("w5.set4.error",  32'(b_error),  32'd0);
        chk("w5.set4.bitmap", 32'(b_bitmap), 32'h10);
        chk("w5.set4.onehot", 32'(b_onehot), 32'h10);
        chk("w5.set4.count",  32'(b_count),  32'd1);
        b_set_valid = 1'b0; b_clr_valid = 1'b1; b_clr_index = 3'd7; step();
        chk("w5.clr7.error",  32'(b_error),  32'd1);
        chk("w5.clr7.bitmap", 32'(b_bitmap), 32'h10);
        b_clr_valid = 1'b0; step();
        chk("w5.idle.error",  32'(b_error),  32'd0);
        chk("w5.idle.full",   32'(b_full),   32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
